// File: rtl/halt_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module  : halt_dump_pkg
// Brief   : Shared state encoding, stop-cause codes and sentinel defaults.
// Revision: 1.0
// ============================================================================
package halt_dump_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_run     = 3'd0;
    localparam state_t c_st_drain   = 3'd1;
    localparam state_t c_st_issue   = 3'd2;
    localparam state_t c_st_wait    = 3'd3;
    localparam state_t c_st_present = 3'd4;
    localparam state_t c_st_done    = 3'd5;

    localparam logic STOP_CAUSE_SENTINEL = 1'b0;
    localparam logic STOP_CAUSE_SHOW     = 1'b1;

    localparam logic [31:0] c_default_halt_addr = 32'hFFFF_FFFF;
    localparam logic [31:0] c_default_halt_data = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/halt_dump_ctrl_halt_detect.sv
`default_nettype none
// ============================================================================
// Module  : halt_detect
// Brief   : Sentinel write compare plus the sticky stop / cause / run flags.
// Revision: 1.0
// ============================================================================
module halt_detect
    import halt_dump_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}},
    parameter logic [DATA_W-1:0] HALT_DATA = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mon_ce,
    input  logic              i_mon_we,
    input  logic [ADDR_W-1:0] i_mon_addr,
    input  logic [DATA_W-1:0] i_mon_wrdata,
    input  logic              i_show,
    output logic              o_trig,
    output logic              o_cpu_run,
    output logic              o_stop,
    output logic              o_stop_cause
);

    logic w_sentinel;
    logic r_stop_q;
    logic w_stop_d;
    logic r_cause_q;
    logic w_cause_d;

    assign w_sentinel = i_mon_ce & i_mon_we
                      & (i_mon_addr == HALT_ADDR)
                      & (i_mon_wrdata == HALT_DATA);

    // Once stopped, further sentinels or show requests are ignored until reset.
    assign o_trig = ~r_stop_q & (w_sentinel | i_show);

    always_comb begin
        w_stop_d  = r_stop_q;
        w_cause_d = r_cause_q;
        if (o_trig) begin
            w_stop_d  = 1'b1;
            w_cause_d = w_sentinel ? STOP_CAUSE_SENTINEL : STOP_CAUSE_SHOW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stop_q  <= 1'b0;
            r_cause_q <= STOP_CAUSE_SENTINEL;
        end else begin
            r_stop_q  <= w_stop_d;
            r_cause_q <= w_cause_d;
        end
    end

    assign o_cpu_run    = ~r_stop_q;
    assign o_stop       = r_stop_q;
    assign o_stop_cause = r_cause_q;

endmodule
`default_nettype wire

// File: rtl/halt_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : halt_dump_ctrl
// Brief   : Freezes the CPU on sentinel/show, drains, then streams out memory.
// Revision: 1.0
// ============================================================================
module halt_dump_ctrl
    import halt_dump_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 512,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = {ADDR_W{1'b1}},
    parameter logic [DATA_W-1:0] HALT_DATA    = {DATA_W{1'b1}},
    parameter int                DRAIN_CYCLES = 5,
    parameter int                RD_LAT       = 1,
    parameter int                CNT_W        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mon_ce,
    input  logic                     mon_we,
    input  logic [ADDR_W-1:0]        mon_addr,
    input  logic [DATA_W-1:0]        mon_wrdata,
    input  logic                     show,
    output logic                     cpu_run,
    output logic                     stop,
    output logic                     stop_cause,
    output logic                     dmp_ce,
    output logic [$clog2(DEPTH)-1:0] dmp_addr,
    input  logic [DATA_W-1:0]        dmp_rdata,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [$clog2(DEPTH)-1:0] dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done,
    output logic [CNT_W-1:0]         cycle_count
);

    localparam int c_aw  = $clog2(DEPTH);
    localparam int c_drw = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int c_lw  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [c_aw-1:0]  c_last_idx   = c_aw'(DEPTH - 1);
    localparam logic [c_drw-1:0] c_drain_last = c_drw'(DRAIN_CYCLES - 1);
    localparam logic [c_lw-1:0]  c_lat_last   = c_lw'(RD_LAT - 1);

    logic w_trig;

    state_t             r_state_q,     w_state_d;
    logic [c_drw-1:0]   r_drain_q,     w_drain_d;
    logic [c_lw-1:0]    r_lat_q,       w_lat_d;
    logic [c_aw-1:0]    r_idx_q,       w_idx_d;
    logic [c_aw-1:0]    r_dump_addr_q, w_dump_addr_d;
    logic [DATA_W-1:0]  r_dump_data_q, w_dump_data_d;
    logic               r_valid_q,     w_valid_d;
    logic               r_done_q,      w_done_d;
    logic [CNT_W-1:0]   r_cnt_q,       w_cnt_d;

    halt_detect #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .HALT_ADDR (HALT_ADDR),
        .HALT_DATA (HALT_DATA)
    ) u_halt_detect (
        .clk          (clk),
        .rst          (rst),
        .i_mon_ce     (mon_ce),
        .i_mon_we     (mon_we),
        .i_mon_addr   (mon_addr),
        .i_mon_wrdata (mon_wrdata),
        .i_show       (show),
        .o_trig       (w_trig),
        .o_cpu_run    (cpu_run),
        .o_stop       (stop),
        .o_stop_cause (stop_cause)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_drain_d     = r_drain_q;
        w_lat_d       = r_lat_q;
        w_idx_d       = r_idx_q;
        w_dump_addr_d = r_dump_addr_q;
        w_dump_data_d = r_dump_data_q;
        w_valid_d     = r_valid_q;
        w_done_d      = r_done_q;
        w_cnt_d       = r_cnt_q;

        case (r_state_q)
            c_st_run: begin
                // The detect cycle itself is still a run cycle.
                if (r_cnt_q != {CNT_W{1'b1}}) begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
                if (w_trig) begin
                    w_state_d = c_st_drain;
                    w_drain_d = '0;
                end
            end
            c_st_drain: begin
                if (r_drain_q == c_drain_last) begin
                    w_state_d = c_st_issue;
                end else begin
                    w_drain_d = r_drain_q + c_drw'(1);
                end
            end
            c_st_issue: begin
                w_state_d = c_st_wait;
                w_lat_d   = '0;
            end
            c_st_wait: begin
                if (r_lat_q == c_lat_last) begin
                    w_dump_data_d = dmp_rdata;
                    w_dump_addr_d = r_idx_q;
                    w_valid_d     = 1'b1;
                    w_state_d     = c_st_present;
                end else begin
                    w_lat_d = r_lat_q + c_lw'(1);
                end
            end
            c_st_present: begin
                if (r_valid_q && dump_ready) begin
                    w_valid_d = 1'b0;
                    if (r_idx_q == c_last_idx) begin
                        w_done_d  = 1'b1;
                        w_state_d = c_st_done;
                    end else begin
                        w_idx_d   = r_idx_q + c_aw'(1);
                        w_state_d = c_st_issue;
                    end
                end
            end
            c_st_done: begin
                w_state_d = c_st_done;
            end
            default: begin
                w_state_d = c_st_run;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q     <= c_st_run;
            r_drain_q     <= '0;
            r_lat_q       <= '0;
            r_idx_q       <= '0;
            r_dump_addr_q <= '0;
            r_dump_data_q <= '0;
            r_valid_q     <= 1'b0;
            r_done_q      <= 1'b0;
            r_cnt_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_drain_q     <= w_drain_d;
            r_lat_q       <= w_lat_d;
            r_idx_q       <= w_idx_d;
            r_dump_addr_q <= w_dump_addr_d;
            r_dump_data_q <= w_dump_data_d;
            r_valid_q     <= w_valid_d;
            r_done_q      <= w_done_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    assign dmp_ce      = (r_state_q == c_st_issue);
    assign dmp_addr    = r_idx_q;
    assign dump_valid  = r_valid_q;
    assign dump_addr   = r_dump_addr_q;
    assign dump_data   = r_dump_data_q;
    assign dump_done   = r_done_q;
    assign cycle_count = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_halt_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_halt_dump_ctrl
// Brief   : Two builds (RD_LAT=1 and RD_LAT=3, DEPTH=8) driven by shared stimulus.
// Revision: 1.0
// ============================================================================
module tb_halt_dump_ctrl;

    localparam int DEPTH = 8;
    localparam int DRAIN = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_ce = 1'b0, mon_we = 1'b0, show = 1'b0, dump_ready = 1'b1;
    logic [31:0] mon_addr = '0, mon_wrdata = '0;

    logic        a_cpu_run, a_stop, a_cause, a_dmp_ce, a_valid, a_done;
    logic [2:0]  a_dmp_addr, a_dump_addr;
    logic [31:0] a_rdata, a_data, a_cnt;
    logic        b_cpu_run, b_stop, b_cause, b_dmp_ce, b_valid, b_done;
    logic [2:0]  b_dmp_addr, b_dump_addr;
    logic [31:0] b_rdata, b_data, b_cnt;

    halt_dump_ctrl #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .mon_ce(mon_ce), .mon_we(mon_we), .mon_addr(mon_addr),
        .mon_wrdata(mon_wrdata), .show(show), .cpu_run(a_cpu_run), .stop(a_stop),
        .stop_cause(a_cause), .dmp_ce(a_dmp_ce), .dmp_addr(a_dmp_addr), .dmp_rdata(a_rdata),
        .dump_valid(a_valid), .dump_ready(dump_ready), .dump_addr(a_dump_addr),
        .dump_data(a_data), .dump_done(a_done), .cycle_count(a_cnt));

    halt_dump_ctrl #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .mon_ce(mon_ce), .mon_we(mon_we), .mon_addr(mon_addr),
        .mon_wrdata(mon_wrdata), .show(show), .cpu_run(b_cpu_run), .stop(b_stop),
        .stop_cause(b_cause), .dmp_ce(b_dmp_ce), .dmp_addr(b_dmp_addr), .dmp_rdata(b_rdata),
        .dump_valid(b_valid), .dump_ready(dump_ready), .dump_addr(b_dump_addr),
        .dump_data(b_data), .dump_done(b_done), .cycle_count(b_cnt));

    initial forever #5 clk = ~clk;

    // Memory model: read pipelines of depth 1 and 3; idle slots carry a poison word.
    logic [31:0] mem [DEPTH];
    logic [31:0] pa;
    logic [31:0] pb [3];
    always @(posedge clk) begin
        pa    <= a_dmp_ce ? mem[a_dmp_addr] : 32'hDEAD_BEEF;
        pb[0] <= b_dmp_ce ? mem[b_dmp_addr] : 32'hDEAD_BEEF;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign a_rdata = pa;
    assign b_rdata = pb[2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rel_cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = stall 4 cycles on beat 2, 2 = random.
    int rdy_mode = 0;
    int stall_left = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: begin
                if (a_valid && a_dump_addr == 3'd2 && stall_left > 0) begin
                    dump_ready = 1'b0;
                    stall_left--;
                end else begin
                    dump_ready = 1'b1;
                end
            end
            2:       dump_ready = 1'($urandom_range(0, 1));
            default: dump_ready = 1'b1;
        endcase
    end

    // Protocol monitor and scoreboard capture.
    logic [63:0] beats_a [$];
    logic [63:0] beats_b [$];
    int          beat_cyc [$];
    int          stab_err = 0, ce_err = 0, lat_err = 0;
    int          stop_cyc = -1, first_ce_cyc = -1;
    logic        a_pstop = 0, a_hold = 0, a_pv = 0, a_pend = 0;
    logic        b_hold = 0, b_pv = 0, b_pend = 0;
    logic [2:0]  a_ha, b_ha, a_ia, b_ia;
    logic [31:0] a_hd, b_hd;
    int          a_ic = 0, b_ic = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            a_pstop = 0; a_hold = 0; a_pv = 0; a_pend = 0;
            b_hold = 0; b_pv = 0; b_pend = 0;
        end else begin
            if (a_dmp_ce && (a_cpu_run || a_valid)) ce_err++;
            if (b_dmp_ce && (b_cpu_run || b_valid)) ce_err++;
            if (a_stop && !a_pstop) stop_cyc = cyc;
            if (a_dmp_ce && first_ce_cyc < 0) first_ce_cyc = cyc;
            if (a_hold && (!a_valid || a_dump_addr != a_ha || a_data != a_hd)) stab_err++;
            if (b_hold && (!b_valid || b_dump_addr != b_ha || b_data != b_hd)) stab_err++;
            a_hold = a_valid && !dump_ready; a_ha = a_dump_addr; a_hd = a_data;
            b_hold = b_valid && !dump_ready; b_ha = b_dump_addr; b_hd = b_data;
            if (a_valid && dump_ready) begin
                beats_a.push_back({29'b0, a_dump_addr, a_data});
                beat_cyc.push_back(cyc);
            end
            if (b_valid && dump_ready) beats_b.push_back({29'b0, b_dump_addr, b_data});
            if (a_dmp_ce) begin a_ic = cyc; a_ia = a_dmp_addr; a_pend = 1; end
            if (b_dmp_ce) begin b_ic = cyc; b_ia = b_dmp_addr; b_pend = 1; end
            // Valid appears RD_LAT+1 cycles after the read request.
            if (a_valid && !a_pv) begin
                if (!a_pend || cyc - a_ic != 2 || a_dump_addr != a_ia || a_data != mem[a_ia]) lat_err++;
                a_pend = 0;
            end
            if (b_valid && !b_pv) begin
                if (!b_pend || cyc - b_ic != 4 || b_dump_addr != b_ia || b_data != mem[b_ia]) lat_err++;
                b_pend = 0;
            end
            a_pstop = a_stop; a_pv = a_valid; b_pv = b_valid;
        end
    end

    task automatic set_idle();
        mon_ce = 0; mon_we = 0; mon_addr = '0; mon_wrdata = '0; show = 0;
    endtask

    task automatic clear_mon();
        beats_a.delete(); beats_b.delete(); beat_cyc.delete();
        stab_err = 0; ce_err = 0; lat_err = 0; stop_cyc = -1; first_ce_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
        clear_mon();
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ce, input logic we, input logic [31:0] ad,
                         input logic [31:0] dt, input logic sh);
        mon_ce = ce; mon_we = we; mon_addr = ad; mon_wrdata = dt; show = sh;
        @(posedge clk);
        #1 set_idle();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_a"}, {a_cpu_run, a_stop, a_cause, a_dmp_ce, a_valid, a_done,
                            a_dmp_addr, a_dump_addr, a_data, a_cnt}, {1'b1, 5'b0, 6'b0, 64'b0});
        check({tag, "_b"}, {b_cpu_run, b_stop, b_cause, b_dmp_ce, b_valid, b_done,
                            b_dmp_addr, b_dump_addr, b_data, b_cnt}, {1'b1, 5'b0, 6'b0, 64'b0});
    endtask

    task automatic check_halted(input string tag, input logic cause, input int exp_cnt);
        @(negedge clk);
        check({tag, "_flags"}, {a_cpu_run, a_stop, a_cause, b_cpu_run, b_stop, b_cause},
              {1'b0, 1'b1, cause, 1'b0, 1'b1, cause});
        check({tag, "_cnt"}, {a_cnt, b_cnt}, {exp_cnt[31:0], exp_cnt[31:0]});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(a_done && b_done) && n < 800) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {63'b0, a_done && b_done}, 64'd1);
    endtask

    task automatic check_beats(input string tag);
        int bad = 0;
        foreach (beats_a[i]) if (beats_a[i] !== {32'(i), mem[i]}) bad++;
        foreach (beats_b[i]) if (beats_b[i] !== {32'(i), mem[i]}) bad++;
        check({tag, "_nbeats"}, {beats_a.size(), beats_b.size()}, {32'(DEPTH), 32'(DEPTH)});
        check({tag, "_beat_bad"}, 64'(bad), 64'd0);
        check({tag, "_proto"}, {stab_err, ce_err + lat_err}, 64'd0);
    endtask

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        show;
        logic        exp_stop;
        logic        exp_cause;
    } vec_t;

    vec_t vt [7];

    initial begin
        int n;
        int bad;
        vt[0] = '{1, 1, 32'h0000_0010, 32'hFFFF_FFFF, 0, 0, 0};
        vt[1] = '{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0};
        vt[2] = '{0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0};
        vt[3] = '{1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0};
        vt[4] = '{1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0};
        vt[5] = '{0, 0, 32'h0000_0000, 32'h0000_0000, 1, 1, 1};
        vt[6] = '{1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0};
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 3);

        #2 rst = 1'b0;
        #1 check_reset_outs("reset_async");
        @(negedge clk);
        rst = 1'b1;

        // Table: single-cycle bus patterns; run cycles = edges seen before the stop.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            n = 3 + v;
            run_idle(n);
            pulse(vt[v].ce, vt[v].we, vt[v].addr, vt[v].data, vt[v].show);
            run_idle(1);
            @(negedge clk);
            check($sformatf("vec%0d_stop", v), {a_stop, a_cause, a_cpu_run, b_stop},
                  {vt[v].exp_stop, vt[v].exp_stop & vt[v].exp_cause, !vt[v].exp_stop, vt[v].exp_stop});
            check($sformatf("vec%0d_cnt", v), 64'(a_cnt), vt[v].exp_stop ? 64'(n + 1) : 64'(n + 2));
        end

        // Sentinel at cycle 100 after an ordinary write, full dump with ready high.
        do_reset();
        rdy_mode = 0;
        run_idle(10);
        pulse(1, 1, 32'h0000_0010, 32'hFFFF_FFFF, 0);
        run_idle(89);
        pulse(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check_halted("sent100", 1'b0, 101);
        wait_done("sent100");
        check_beats("sent100");
        check("drain_gap", 64'(first_ce_cyc - stop_cyc), 64'(DRAIN));
        bad = 0;
        for (int i = 1; i < beat_cyc.size(); i++) if (beat_cyc[i] - beat_cyc[i-1] != 3) bad++;
        check("throughput", 64'(bad), 64'd0);
        run_idle(12);
        @(negedge clk);
        check("done_hold", {a_done, a_valid, a_dump_addr, a_cnt, 29'(beats_a.size())},
              {1'b1, 1'b0, 3'd7, 32'd101, 29'(DEPTH)});

        // Backpressure on beat 2.
        do_reset();
        rdy_mode = 1;
        stall_left = 4;
        run_idle(7);
        pulse(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_done("bp");
        check_beats("bp");
        check("bp_stalled", 64'(stall_left), 64'd0);

        // Manual show at cycle 50, then show+sentinel together.
        do_reset();
        rdy_mode = 0;
        run_idle(50);
        pulse(0, 0, 32'h0, 32'h0, 1);
        check_halted("show50", 1'b1, 51);
        wait_done("show50");
        check_beats("show50");
        do_reset();
        run_idle(4);
        pulse(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        check_halted("both", 1'b0, 5);

        // Randomized bus traffic, random halt time, random ready, random memory.
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            do_reset();
            rdy_mode = 2;
            n = $urandom_range(20, 150);
            for (int k = 0; k < n; k++) begin
                mon_ce = 1'($urandom); mon_we = 1'($urandom);
                case ($urandom_range(0, 3))
                    0: begin mon_addr = '1; mon_wrdata = '1; mon_we = 1'b0; end
                    1: begin mon_addr = '1; mon_wrdata = $urandom & 32'hFFFF_FFFE; end
                    2: begin mon_addr = $urandom & 32'hFFFF_FFFE; mon_wrdata = '1; end
                    default: begin
                        mon_addr = $urandom; mon_wrdata = $urandom;
                        if (mon_addr == '1) mon_addr[0] = 1'b0;
                    end
                endcase
                @(posedge clk);
                #1;
            end
            pulse(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
            check_halted($sformatf("rnd%0d", it), 1'b0, n + 1);
            wait_done($sformatf("rnd%0d", it));
            check_beats($sformatf("rnd%0d", it));
        end

        // Asynchronous reset while beat 5 is presented, then a fresh dump.
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 3);
        do_reset();
        rdy_mode = 0;
        run_idle(6);
        pulse(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        n = 0;
        while (!(a_valid && a_dump_addr == 3'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_addr5", {a_valid, a_dump_addr}, {1'b1, 3'd5});
        #2 rst = 1'b0;
        #1 check_reset_outs("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
        clear_mon();
        run_idle(3);
        pulse(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check_halted("restart", 1'b0, 4);
        wait_done("restart");
        check_beats("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/halt_dump_ctrl.md
Name: halt_dump_ctrl

Overview:
- Simulation/board control block between the CPU core, data memory and host-visible debug stream.
- Watches the CPU data-memory write bus for a halt sentinel, or takes a manual `show` request. It then freezes the CPU and waits a programmable pipeline-drain interval.
- Finally it sequences a word-by-word dump of data memory over a valid/ready stream, with a run-cycle counter.
- Successor to the fixed top-level wiring: sentinel, depth, widths, drain and memory latency are all parametrised.

Parameters:
- ADDR_W, 32, CPU data address width (byte address).
- DATA_W, 32, data word width.
- DEPTH, 512, number of data-memory words dumped; power of two, >=2.
- HALT_ADDR, {ADDR_W{1'b1}}, sentinel write address.
- HALT_DATA, {DATA_W{1'b1}}, sentinel write data.
- DRAIN_CYCLES, 5, cycles between halt detect and first dump read; >=1.
- RD_LAT, 1, memory read latency in cycles; >=1.
- CNT_W, 32, cycle counter width.

Ports:
- clk, in, 1, system clock; all state on rising edge.
- rst, in, 1, asynchronous active-low reset.
- mon_ce, in, 1, CPU data-memory chip enable.
- mon_we, in, 1, CPU data-memory write strobe.
- mon_addr, in, ADDR_W, CPU data byte address.
- mon_wrdata, in, DATA_W, CPU write data.
- show, in, 1, manual dump request; level, sampled in RUN only.
- cpu_run, out, 1, CPU/instruction-fetch enable.
- stop, out, 1, sticky halted flag.
- stop_cause, out, 1, 0=sentinel, 1=show; valid while stop=1.
- dmp_ce, out, 1, dump read enable to memory (muxed over CPU port at top level when cpu_run=0).
- dmp_addr, out, $clog2(DEPTH), word index being read.
- dmp_rdata, in, DATA_W, memory read data, valid RD_LAT cycles after dmp_ce.
- dump_valid, out, 1, stream word valid.
- dump_ready, in, 1, stream consumer ready.
- dump_addr, out, $clog2(DEPTH), word index of dump_data.
- dump_data, out, DATA_W, dumped word.
- dump_done, out, 1, sticky; all DEPTH words accepted.
- cycle_count, out, CNT_W, cycles spent with cpu_run=1.

Behaviour:
- Reset (rst=0, async):
  - state=RUN; cpu_run=1.
  - stop, stop_cause, dmp_ce, dump_valid and dump_done are 0.
  - dmp_addr, dump_addr, dump_data and cycle_count are 0.
- RUN:
  - cycle_count increments every cycle and saturates at all-ones.
  - Halt event = mon_ce & mon_we & (mon_addr==HALT_ADDR) & (mon_wrdata==HALT_DATA).
  - On halt event, or on show=1: next cycle cpu_run=0, stop=1, stop_cause set, state=DRAIN, drain counter=0.
  - Halt event and show in the same cycle: stop_cause=0 (sentinel wins).
  - cycle_count includes the detect cycle, then freezes.
- DRAIN: counter increments each cycle; when it reaches DRAIN_CYCLES-1, state=ISSUE. Sentinel and show are ignored from DRAIN onward.
- ISSUE: dmp_ce=1 for exactly one cycle with dmp_addr=current index; state=WAIT with latency counter=0.
- WAIT:
  - Count RD_LAT cycles, so data arrives in the cycle after ISSUE when RD_LAT=1.
  - In the arrival cycle, capture dmp_rdata into dump_data and the index into dump_addr, set dump_valid=1, state=PRESENT.
- PRESENT:
  - dump_valid and dump_data are held stable until dump_valid&dump_ready.
  - On acceptance, if index==DEPTH-1: dump_valid=0, dump_done=1, state=DONE.
  - Otherwise index+1, dump_valid=0, state=ISSUE.
  - Throughput: one word per (RD_LAT+2) cycles with ready held high.
- DONE: terminal. Outputs hold; only reset leaves. The index does not wrap.
- dump_ready is ignored while dump_valid=0.
- Reset mid-dump aborts immediately, with all outputs at reset values. The CPU resumes from reset.
- dmp_ce is never asserted while cpu_run=1.

Decomposition:
- Shared package halt_dump_pkg:
  - state enum {RUN, DRAIN, ISSUE, WAIT, PRESENT, DONE}.
  - STOP_CAUSE_SENTINEL=0 and STOP_CAUSE_SHOW=1.
  - Default sentinel constants.
- One natural sub-module, halt_detect: combinational sentinel compare plus the registered stop/stop_cause/cpu_run flags.
- FSM, counters and dump datapath stay in the top module.

Test Plan:
- Sentinel halt: write to addr 0x0000_0010, then write 0xFFFF_FFFF to addr 0xFFFF_FFFF at cycle 100 -> cpu_run falls at cycle 101, stop=1, stop_cause=0, cycle_count frozen at 101 (counting from 1 after reset release). No halt for a non-sentinel write or for a sentinel with mon_we=0.
- Full dump, ready tied high, DEPTH=8, RD_LAT=1, memory word i=i*3 -> eight beats with dump_addr 0..7 and data 0,3,...,21. First dmp_ce exactly DRAIN_CYCLES cycles after stop rises. dump_done rises after the beat at addr 7.
- Backpressure: dump_ready=0 for 4 cycles on the beat at addr 2 -> dump_valid/dump_data/dump_addr stable; no dmp_ce issued; no beat lost or duplicated.
- Manual show: pulse show=1 at cycle 50 with no sentinel -> stop=1, stop_cause=1, and the dump proceeds identically. Show and sentinel together -> stop_cause=0.
- RD_LAT=3 build -> dump_data captured exactly 3 cycles after each dmp_ce; data correct.
- Async reset asserted mid-PRESENT at addr 5 -> outputs at reset values immediately (without a clock edge), cpu_run=1; after release, a new sentinel restarts the dump from addr 0.
